// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: hazard stalls, multi-cycle mul/div busy window,
// memory-wait freeze, branch flush, hazard-deadlock detection and stall accounting.
module pipe_stall_ctrl #(
  parameter int unsigned MD_LATENCY = 32,
  parameter int unsigned HAZ_LIMIT  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HazardBit,
  input  logic        md_start,
  input  logic        mem_wait,
  input  logic        branch_taken,
  output logic        PCWrite,
  output logic        IF_ID_write,
  output logic        ID_EX_write,
  output logic        EX_MEM_write,
  output logic        ControlMuxBit,
  output logic        IF_ID_flush,
  output logic        ex_bubble,
  output logic        md_done,
  output logic        deadlock,
  output logic [15:0] stall_count
);

  // state   | meaning
  // RUN     | normal issue; hazard stalls and flushes handled per cycle
  // MD_BUSY | mul/div occupying EX, front end frozen until md_cnt expires
  // HALT    | hazard stall ran too long; frozen until reset
  typedef enum logic [1:0] {RUN, MD_BUSY, HALT} state_t;

  localparam logic [5:0] MD_LOAD  = 6'(MD_LATENCY - 1);
  localparam logic [8:0] HAZ_LIM9 = 9'(HAZ_LIMIT);

  state_t      state_q, state_d;
  logic [5:0]  md_cnt_q, md_cnt_d;
  logic [7:0]  haz_cnt_q, haz_cnt_d;
  logic [15:0] stall_count_q, stall_count_d;
  logic        deadlock_q, deadlock_d;
  logic        haz_stall;

  always_comb begin
    PCWrite       = 1'b1;
    IF_ID_write   = 1'b1;
    ID_EX_write   = 1'b1;
    EX_MEM_write  = 1'b1;
    ControlMuxBit = 1'b0;
    IF_ID_flush   = 1'b0;
    ex_bubble     = 1'b0;
    haz_stall     = 1'b0;
    if (reset) begin
      // outputs forced to the run defaults while reset is held
    end else if (state_q == HALT || mem_wait) begin
      PCWrite      = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_write  = 1'b0;
      EX_MEM_write = 1'b0;
    end else if (branch_taken) begin
      IF_ID_flush   = 1'b1;
      ControlMuxBit = 1'b1;
    end else if (state_q == MD_BUSY) begin
      PCWrite     = 1'b0;
      IF_ID_write = 1'b0;
      ID_EX_write = 1'b0;
      ex_bubble   = 1'b1;
    end else if (HazardBit) begin
      PCWrite       = 1'b0;
      IF_ID_write   = 1'b0;
      ControlMuxBit = 1'b1;
      haz_stall     = 1'b1;
    end
  end

  assign md_done     = !reset && (state_q == MD_BUSY) && !mem_wait && (md_cnt_q == 6'd0);
  assign deadlock    = deadlock_q;
  assign stall_count = stall_count_q;

  always_comb begin
    state_d       = state_q;
    md_cnt_d      = md_cnt_q;
    deadlock_d    = deadlock_q;
    haz_cnt_d     = haz_stall ? haz_cnt_q + 8'd1 : 8'd0;
    stall_count_d = stall_count_q;
    if (!PCWrite && stall_count_q != 16'hFFFF)
      stall_count_d = stall_count_q + 16'd1;
    case (state_q)
      RUN: begin
        // a deadlock detected in the same cycle as md_start wins
        if (haz_stall && ({1'b0, haz_cnt_q} + 9'd1 == HAZ_LIM9)) begin
          state_d    = HALT;
          deadlock_d = 1'b1;
        end else if (md_start && !mem_wait && !branch_taken) begin
          state_d  = MD_BUSY;
          md_cnt_d = MD_LOAD;
        end
      end
      MD_BUSY: begin
        if (!mem_wait) begin
          if (md_cnt_q == 6'd0) state_d = RUN;
          else                  md_cnt_d = md_cnt_q - 6'd1;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      md_cnt_q      <= 6'd0;
      haz_cnt_q     <= 8'd0;
      stall_count_q <= 16'd0;
      deadlock_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      md_cnt_q      <= md_cnt_d;
      haz_cnt_q     <= haz_cnt_d;
      stall_count_q <= stall_count_d;
      deadlock_q    <= deadlock_d;
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_pipe_stall_ctrl;

  localparam int MD_LAT  = 4;
  localparam int HAZ_LIM = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic HazardBit = 1'b0, md_start = 1'b0, mem_wait = 1'b0, branch_taken = 1'b0;
  logic PCWrite, IF_ID_write, ID_EX_write, EX_MEM_write;
  logic ControlMuxBit, IF_ID_flush, ex_bubble, md_done, deadlock;
  logic [15:0] stall_count;

  int tests = 0;
  int fails = 0;

  pipe_stall_ctrl #(.MD_LATENCY(MD_LAT), .HAZ_LIMIT(HAZ_LIM)) dut (
    .clk(clk), .reset(reset), .HazardBit(HazardBit), .md_start(md_start),
    .mem_wait(mem_wait), .branch_taken(branch_taken), .PCWrite(PCWrite),
    .IF_ID_write(IF_ID_write), .ID_EX_write(ID_EX_write), .EX_MEM_write(EX_MEM_write),
    .ControlMuxBit(ControlMuxBit), .IF_ID_flush(IF_ID_flush), .ex_bubble(ex_bubble),
    .md_done(md_done), .deadlock(deadlock), .stall_count(stall_count));

  always #5 clk = ~clk;

  // Behavioural model: busy_left counts remaining mul/div cycles including the current one.
  bit m_halt = 0, m_dead = 0;
  int m_busy_left = 0, m_haz = 0, m_stall = 0;

  always @(negedge clk) begin
    logic [8:0] exp_o, act_o;
    bit pc, ifid, idex, exmem, cmb, fl, exb, dn, row_e;
    pc = 1; ifid = 1; idex = 1; exmem = 1; cmb = 0; fl = 0; exb = 0; dn = 0; row_e = 0;
    if (!reset) begin
      if (m_halt || mem_wait) begin
        pc = 0; ifid = 0; idex = 0; exmem = 0;
      end else if (branch_taken) begin
        fl = 1; cmb = 1;
      end else if (m_busy_left > 0) begin
        pc = 0; ifid = 0; idex = 0; exb = 1;
      end else if (HazardBit) begin
        pc = 0; ifid = 0; cmb = 1; row_e = 1;
      end
      dn = (m_busy_left == 1) && !mem_wait;
    end
    exp_o = {pc, ifid, idex, exmem, cmb, fl, exb, dn, (m_dead && !reset)};
    act_o = {PCWrite, IF_ID_write, ID_EX_write, EX_MEM_write, ControlMuxBit,
             IF_ID_flush, ex_bubble, md_done, deadlock};
    tests++;
    if (act_o !== exp_o) begin
      fails++;
      $display("FAIL outputs @%0t: got %b expected %b (pc,ifid,idex,exmem,cmb,flush,exb,done,dl)",
               $time, act_o, exp_o);
    end
    tests++;
    if (stall_count !== 16'(reset ? 0 : m_stall)) begin
      fails++;
      $display("FAIL stall_count @%0t: got %0d expected %0d", $time, stall_count, reset ? 0 : m_stall);
    end
    if (reset) begin
      m_halt = 0; m_dead = 0; m_busy_left = 0; m_haz = 0; m_stall = 0;
    end else begin
      if (!pc && m_stall < 65535) m_stall++;
      if (row_e) begin
        m_haz++;
        if (m_haz == HAZ_LIM) begin m_halt = 1; m_dead = 1; end
      end else begin
        m_haz = 0;
      end
      if (m_busy_left > 0) begin
        if (!mem_wait) m_busy_left--;
      end else if (!m_halt && md_start && !mem_wait && !branch_taken) begin
        m_busy_left = MD_LAT;
      end
    end
  end

  task automatic set_in(input logic h, input logic ms, input logic mw, input logic bt);
    @(posedge clk); #1;
    HazardBit = h; md_start = ms; mem_wait = mw; branch_taken = bt;
  endtask

  task automatic sample;
    @(negedge clk); #1;
  endtask

  task automatic lit(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    sample;
    lit("rst_pcwrite", 16'(PCWrite), 16'd1);
    lit("rst_stall_count", stall_count, 16'd0);
    @(posedge clk); #1 reset = 1'b0;

    // two hazard cycles
    set_in(1, 0, 0, 0); sample;
    lit("haz1_pc", 16'(PCWrite), 16'd0); lit("haz1_cmb", 16'(ControlMuxBit), 16'd1);
    set_in(1, 0, 0, 0); sample;
    lit("haz2_pc", 16'(PCWrite), 16'd0); lit("haz2_cmb", 16'(ControlMuxBit), 16'd1);
    set_in(0, 0, 0, 0); sample;
    lit("haz_end_pc", 16'(PCWrite), 16'd1); lit("haz_end_cmb", 16'(ControlMuxBit), 16'd0);
    lit("haz_stall_count", stall_count, 16'd2); lit("haz_deadlock", 16'(deadlock), 16'd0);

    // branch beats hazard
    set_in(1, 0, 0, 1); sample;
    lit("br_flush", 16'(IF_ID_flush), 16'd1); lit("br_cmb", 16'(ControlMuxBit), 16'd1);
    lit("br_pc", 16'(PCWrite), 16'd1);
    set_in(0, 0, 0, 0); sample;
    lit("br_stall_count", stall_count, 16'd2);

    // plain mul/div
    set_in(0, 1, 0, 0); sample;
    lit("md_issue_bubble", 16'(ex_bubble), 16'd0);
    for (int i = 0; i < MD_LAT; i++) begin
      set_in(0, 0, 0, 0); sample;
      lit($sformatf("md_bubble%0d", i), 16'(ex_bubble), 16'd1);
      lit($sformatf("md_done%0d", i), 16'(md_done), 16'(i == MD_LAT - 1));
    end
    set_in(0, 0, 0, 0); sample;
    lit("md_after_bubble", 16'(ex_bubble), 16'd0); lit("md_after_pc", 16'(PCWrite), 16'd1);
    lit("md_stall_count", stall_count, 16'd6);

    // mul/div with mem_wait in the 2nd busy cycle for 3 cycles
    set_in(0, 1, 0, 0);
    set_in(0, 0, 0, 0); sample; lit("mw_c1_done", 16'(md_done), 16'd0);
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 1, 0); sample;
      lit($sformatf("mw_writes%0d", i), 16'({PCWrite, IF_ID_write, ID_EX_write, EX_MEM_write}), 16'd0);
      lit($sformatf("mw_done%0d", i), 16'(md_done), 16'd0);
    end
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0); sample;
      lit($sformatf("mw_tail_done%0d", i), 16'(md_done), 16'(i == 2));
    end

    // reset in the 2nd busy cycle
    set_in(0, 1, 0, 0);
    set_in(0, 0, 0, 0);
    @(posedge clk); #1 reset = 1'b1;
    sample;
    lit("rb_pc", 16'(PCWrite), 16'd1); lit("rb_bubble", 16'(ex_bubble), 16'd0);
    lit("rb_done", 16'(md_done), 16'd0); lit("rb_stall_count", stall_count, 16'd0);
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_in(0, 0, 0, 0); sample;
      lit($sformatf("rb_after_done%0d", i), 16'(md_done), 16'd0);
    end

    // hazard held until deadlock
    for (int i = 0; i < HAZ_LIM; i++) begin
      set_in(1, 0, 0, 0); sample;
      lit($sformatf("dl_pre%0d", i), 16'(deadlock), 16'd0);
    end
    set_in(0, 0, 0, 0); sample;
    lit("dl_set", 16'(deadlock), 16'd1);
    lit("dl_writes", 16'({PCWrite, IF_ID_write, ID_EX_write, EX_MEM_write}), 16'd0);
    lit("dl_stall_count", stall_count, 16'd8);
    set_in(0, 1, 0, 1); sample;
    lit("dl_sticky", 16'(deadlock), 16'd1); lit("dl_flush_blocked", 16'(IF_ID_flush), 16'd0);
    @(posedge clk); #1 reset = 1'b1;
    sample;
    lit("dl_reset", 16'(deadlock), 16'd0);
    @(posedge clk); #1 reset = 1'b0;

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk); #1;
      HazardBit    = ($urandom_range(0, 99) < 60);
      md_start     = ($urandom_range(0, 99) < 15);
      mem_wait     = ($urandom_range(0, 99) < 15);
      branch_taken = ($urandom_range(0, 99) < 10);
      reset        = ($urandom_range(0, 149) == 0);
    end
    @(posedge clk); #1;
    reset = 1'b0; HazardBit = 0; md_start = 0; mem_wait = 0; branch_taken = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 Parameter MD_LATENCY, default 32, SHALL set the multiply/divide busy duration in cycles (legal range 1..63).
REQ-002 Parameter HAZ_LIMIT, default 8, SHALL set the number of consecutive hazard-stall cycles at which deadlock is flagged (legal range 1..255).
REQ-003 Ports SHALL be:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- HazardBit  in  1  stall request from hazard detection.
- md_start  in  1  multiply/divide instruction entering EX.
- mem_wait  in  1  data memory not ready.
- branch_taken  in  1  branch resolved taken in EX.
- PCWrite  out  1  PC update enable.
- IF_ID_write  out  1  IF/ID register enable.
- ID_EX_write  out  1  ID/EX register enable.
- EX_MEM_write  out  1  EX/MEM register enable.
- ControlMuxBit  out  1  zero the control bits entering ID/EX (bubble).
- IF_ID_flush  out  1  clear IF/ID to NOP.
- ex_bubble  out  1  zero the control bits entering EX/MEM.
- md_done  out  1  one-cycle pulse: mul/div result ready.
- deadlock  out  1  sticky deadlock flag.
- stall_count  out  16  saturating total stall-cycle count.

Function
REQ-004 The block SHALL use FSM states RUN, MD_BUSY, and HALT, plus a 6-bit md_cnt, an 8-bit haz_cnt, and stall_count.
REQ-005 Outputs SHALL be combinational from state and inputs, using the first matching row below; unlisted outputs take their RUN defaults (all *_write=1, PCWrite=1, everything else 0):
- a) state HALT: PCWrite=0, IF_ID_write=0, ID_EX_write=0, EX_MEM_write=0.
- b) mem_wait=1: PCWrite=0, IF_ID_write=0, ID_EX_write=0, EX_MEM_write=0.
- c) branch_taken=1: IF_ID_flush=1, ControlMuxBit=1.
- d) state MD_BUSY: PCWrite=0, IF_ID_write=0, ID_EX_write=0, ex_bubble=1.
- e) HazardBit=1: PCWrite=0, IF_ID_write=0, ControlMuxBit=1.
- f) otherwise: RUN defaults.
REQ-006 RUN->MD_BUSY SHALL occur when md_start=1, mem_wait=0, branch_taken=0; md_cnt SHALL load MD_LATENCY-1.
REQ-007 In MD_BUSY with mem_wait=0, md_cnt SHALL decrement each cycle; in the cycle md_cnt==0, md_done SHALL be 1 and the next state SHALL be RUN.
REQ-008 In MD_BUSY with mem_wait=1, md_cnt and the state SHALL hold, and md_done SHALL stay 0.
REQ-009 md_start SHALL be ignored when in MD_BUSY or HALT, or when mem_wait=1 or branch_taken=1.
REQ-010 With MD_LATENCY=1, MD_BUSY SHALL last exactly one cycle, with md_done=1 in that cycle.
REQ-011 haz_cnt SHALL increment in each cycle where row e) is selected, and SHALL clear in any cycle where it is not.
REQ-012 When haz_cnt would reach HAZ_LIMIT, the next state SHALL be HALT and deadlock SHALL set.
REQ-013 HALT and deadlock SHALL be left only by reset.
REQ-014 stall_count SHALL increment by 1 in each cycle where PCWrite=0, and SHALL saturate at 16'hFFFF.
REQ-015 branch_taken and HazardBit in the same cycle SHALL resolve as row c): a flush, with no stall.

Reset
REQ-016 While reset=1, asynchronously: state=RUN, md_cnt=0, haz_cnt=0, stall_count=0, deadlock=0.
REQ-017 While reset=1, outputs SHALL be PCWrite=1, IF_ID_write=1, ID_EX_write=1, EX_MEM_write=1, and all other outputs 0.
REQ-018 Reset asserted in MD_BUSY or HALT SHALL abort the operation; after release there SHALL be no md_done pulse.

Verification
REQ-019 HazardBit=1 for 2 cycles -> PCWrite=0 and ControlMuxBit=1 for exactly those 2 cycles; stall_count=2; deadlock=0.
REQ-020 MD_LATENCY=4, md_start pulse -> MD_BUSY for 4 cycles; md_done in the 4th; ex_bubble=1 for 4 cycles; then RUN.
REQ-021 md_start, then mem_wait=1 for 3 cycles starting in the 2nd MD_BUSY cycle -> md_done delayed 3 cycles; all *_write=0 while mem_wait=1.
REQ-022 branch_taken=1 and HazardBit=1 together -> IF_ID_flush=1, ControlMuxBit=1, PCWrite=1; stall_count unchanged.
REQ-023 HazardBit held high with HAZ_LIMIT=8 -> deadlock=1 after the 8th stall cycle; all writes 0; reset clears deadlock.
REQ-024 Reset pulse in the 2nd MD_BUSY cycle -> immediate RUN outputs; no md_done; stall_count=0.
